keccak_squeeze: RTL and testbench
=================================

Name: keccak_squeeze

Overview:
- Output end of the Keccak datapath. It captures the full 25-lane state after the final round (Theta … Iota) and serializes the digest as 64-bit lanes over a valid/ready stream.
- Supports fixed-length SHA3 digests (output lanes ≤ rate lanes) and SHAKE extendable output.
- For SHAKE, it requests another permutation whenever the rate portion is exhausted and more lanes are still owed.
- Sits between the round core and the host output interface.

Parameters:
- RATE_LANES, 17, lanes squeezed per permutation (SHA3-256 = 17, SHAKE128 = 21); legal 1..25.
- LEN_W, 16, width of the requested output-lane count.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  upstream presents a state block.
- load_ready  out  1  block can accept a state.
- state_in  in  1600  lane i at [64*i+63:64*i], lane i = A[x][y] with i = x+5y.
- out_lanes  in  LEN_W  total lanes to emit; sampled only on a load accepted in IDLE.
- out_valid  out  1  out_data holds a valid lane.
- out_ready  in  1  downstream accepts the lane.
- out_data  out  64  current lane, Keccak little-endian lane value, unmodified.
- out_last  out  1  qualifies the final lane of the request.
- perm_req  out  1  one-cycle pulse: run one more permutation on the held state and return it via load.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, EMIT, WAIT_PERM.
- Reset: state = IDLE; load_ready = 1; out_valid = 0; out_last = 0; out_data = 0; perm_req = 0; busy = 0; internal lane index and remaining counter = 0.
- load_ready = 1 in IDLE and WAIT_PERM, 0 in EMIT. It is combinational from the state register.
- IDLE, load accepted with out_lanes = 0: no-op. State stays IDLE and nothing is emitted.
- IDLE, load accepted with out_lanes > 0: latch state_in and out_lanes into remaining, set idx = 0, go to EMIT.
  - Next cycle: out_valid = 1, out_data = lane 0.
  - Latency from load handshake to first valid lane is 1 cycle.
- EMIT:
  - out_data = lane[idx], registered; it holds stable while out_valid && !out_ready.
  - out_last = (remaining == 1).
  - On handshake: remaining decrements.
  - If remaining was 1: out_valid drops next cycle, go to IDLE. load_ready is not high in the handshake cycle itself.
  - Else if idx == RATE_LANES-1: out_valid drops, perm_req pulses for 1 cycle, go to WAIT_PERM.
  - Else: idx increments and the next lane is presented the following cycle. Full throughput is 1 lane/cycle when out_ready is held high.
- WAIT_PERM:
  - On load accept: re-latch state_in, set idx = 0, return to EMIT. out_lanes is ignored; remaining is preserved.
  - perm_req is not re-asserted while waiting.
- out_valid never drops without a handshake, except on reset.
- Lanes beyond RATE_LANES-1 (the capacity) are never emitted.
- Remaining counter: width LEN_W. It never underflows, because 0 is rejected at load.
- Async reset mid-stream: everything returns to reset values immediately. A partially emitted digest is abandoned; no out_last is produced.

Decomposition:
- Package sha3_pkg holds:
  - LANE_W = 64, NUM_LANES = 25, STATE_W = 1600.
  - Rate constants: RATE_SHA3_224 = 18, _256 = 17, _384 = 13, _512 = 9, RATE_SHAKE128 = 21, RATE_SHAKE256 = 17.
  - The state enum, and a lane-slice function lane(state, i).
- The FSM, counters and lane register stay in one module.
- The 25:1 lane mux may be split into keccak_lane_mux (combinational, index → 64-bit lane) so it can be shared with a future absorb block.
- Target size: ~150–250 lines.

Test Plan:
- Basic SHA3-256: RATE_LANES = 17, lane i = {32'hA5A50000+i, 32'h0000_0000+i}, out_lanes = 4, out_ready tied 1.
  - Expect lanes 0..3 on 4 consecutive cycles starting 1 cycle after load; out_last only on lane 3; then IDLE with load_ready = 1.
- Backpressure: same setup, out_ready toggled 1,0,0,1,0,1,1.
  - Expect out_data and out_last stable during stalls, no lane skipped or duplicated, 4 lanes total.
- SHAKE128 multi-block: RATE_LANES = 21, out_lanes = 25.
  - Expect lanes 0..20 emitted, then one perm_req pulse, out_valid = 0.
  - Load a second state with lane i = 64'hDEAD0000_00000000+i: expect lanes 0..3 of it, out_last on the 4th, 25 handshakes total.
- Zero request: load with out_lanes = 0.
  - Expect out_valid never asserted, busy never asserted, load_ready stays 1.
- Reset mid-operation: assert rst_n = 0 after the 2nd lane of an out_lanes = 4 request.
  - Expect all outputs at reset values immediately (asynchronous).
  - A fresh load after release emits from lane 0 with the new count.
- Exact-rate boundary: RATE_LANES = 17, out_lanes = 17.
  - Expect out_last on lane 16, no perm_req, direct return to IDLE.

Source files
------------

// File: rtl/sha3_pkg.sv
// ---------------------------------------------------------------------------
// sha3_pkg
// Shared constants and types for the Keccak/SHA3 datapath blocks.
//   LANE_W / NUM_LANES / STATE_W : geometry of the 5x5x64 Keccak state
//   RATE_*                       : lanes per permutation for each SHA3/SHAKE mode
//   squeezeState_e               : squeeze controller states
//   lane()                       : pick lane i (i = x + 5y) out of a flat state
// ---------------------------------------------------------------------------
package sha3_pkg;

   localparam int LANE_W    = 64;
   localparam int NUM_LANES = 25;
   localparam int STATE_W   = 1600;

   localparam int RATE_SHA3_224 = 18;
   localparam int RATE_SHA3_256 = 17;
   localparam int RATE_SHA3_384 = 13;
   localparam int RATE_SHA3_512 = 9;
   localparam int RATE_SHAKE128 = 21;
   localparam int RATE_SHAKE256 = 17;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_EMIT      = 2'd1,
      ST_WAIT_PERM = 2'd2
   } squeezeState_e;

   // Lane i lives at bits [64*i+63 : 64*i] of the flat state vector.
   function automatic logic [LANE_W-1:0] lane(input logic [STATE_W-1:0] s,
                                              input int unsigned         i);
      return s[LANE_W*i +: LANE_W];
   endfunction

endpackage

// File: rtl/keccak_lane_mux.sv
// ---------------------------------------------------------------------------
// keccak_lane_mux
// Combinational 25:1 lane selector over a flat Keccak state. Kept separate so
// the absorb side can reuse it.
//   state_i : 1600-bit state, lane i at [64*i+63:64*i]
//   idx_i   : lane index 0..24 (out-of-range values yield zero)
//   lane_o  : selected 64-bit lane
// ---------------------------------------------------------------------------
module keccak_lane_mux
   import sha3_pkg::*;
(
   input  logic [STATE_W-1:0] state_i,
   input  logic [4:0]         idx_i,
   output logic [LANE_W-1:0]  lane_o
);

   // One-hot style scan so indices 25..31 fall through to zero instead of
   // reading past the end of the state vector.
   always_comb begin
      lane_o = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (idx_i == 5'(i)) begin
            lane_o = state_i[LANE_W*i +: LANE_W];
         end
      end
   end

endmodule

// File: rtl/keccak_squeeze.sv
// ---------------------------------------------------------------------------
// keccak_squeeze
// Captures the post-permutation Keccak state and streams the digest out one
// 64-bit lane per handshake. When more lanes are owed than one rate block
// holds (SHAKE), it pulses perm_req and waits for the permuted state to come
// back through the load port.
//   clk, rst_n            : clock, asynchronous active-low reset
//   load_valid/load_ready : state block handshake from the round core
//   state_in              : 1600-bit state, lane i = A[x][y], i = x+5y
//   out_lanes             : lanes to emit; sampled only on a load in IDLE
//   out_valid/out_ready   : output lane handshake
//   out_data, out_last    : current lane and final-lane flag
//   perm_req              : one-cycle request for another permutation
//   busy                  : high whenever not IDLE
// ---------------------------------------------------------------------------
module keccak_squeeze
   import sha3_pkg::*;
#(
   parameter int RATE_LANES = 17,
   parameter int LEN_W      = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_valid,
   output logic               load_ready,
   input  logic [STATE_W-1:0] state_in,
   input  logic [LEN_W-1:0]   out_lanes,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [LANE_W-1:0]  out_data,
   output logic               out_last,
   output logic               perm_req,
   output logic               busy
);

   localparam logic [4:0] LAST_IDX = 5'(RATE_LANES - 1);

   squeezeState_e      state_q, state_d;
   logic [STATE_W-1:0] stateReg_q, stateReg_d;
   logic [LEN_W-1:0]   remaining_q, remaining_d;
   logic [4:0]         idx_q, idx_d;
   logic [LANE_W-1:0]  outData_q, outData_d;
   logic               permReq_q, permReq_d;

   logic               loadFire;
   logic               outFire;
   logic               lastLane;
   logic [4:0]         idxNext;
   logic [LANE_W-1:0]  nextLane;

   assign loadFire = load_valid && load_ready;
   assign outFire  = out_valid && out_ready;
   assign lastLane = (remaining_q == LEN_W'(1));
   assign idxNext  = idx_q + 5'd1;

   // The lane after the current one is fetched from the held state so that
   // out_data can be registered and still sustain one lane per cycle.
   keccak_lane_mux uLaneMux (
      .state_i (stateReg_q),
      .idx_i   (idxNext),
      .lane_o  (nextLane)
   );

   // State register for the squeeze controller.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. A zero-length request is swallowed in IDLE; the end of
   // a rate block only detours through WAIT_PERM if lanes are still owed.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (loadFire && (out_lanes != '0)) state_d = ST_EMIT;
         end
         ST_EMIT: begin
            if (outFire) begin
               if (lastLane)                state_d = ST_IDLE;
               else if (idx_q == LAST_IDX)  state_d = ST_WAIT_PERM;
            end
         end
         ST_WAIT_PERM: begin
            if (loadFire) state_d = ST_EMIT;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output decode straight from the state register; out_data and perm_req
   // come from their own registers below.
   always_comb begin
      load_ready = (state_q == ST_IDLE) || (state_q == ST_WAIT_PERM);
      busy       = (state_q != ST_IDLE);
      out_valid  = (state_q == ST_EMIT);
      out_last   = (state_q == ST_EMIT) && lastLane;
   end

   assign out_data = outData_q;
   assign perm_req = permReq_q;

   // Datapath next values. The remaining count is only taken from out_lanes
   // on the first load; reloads after a permutation keep the running count.
   always_comb begin
      stateReg_d  = stateReg_q;
      remaining_d = remaining_q;
      idx_d       = idx_q;
      outData_d   = outData_q;
      permReq_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (loadFire && (out_lanes != '0)) begin
               stateReg_d  = state_in;
               remaining_d = out_lanes;
               idx_d       = '0;
               outData_d   = lane(state_in, 0);
            end
         end
         ST_EMIT: begin
            if (outFire) begin
               remaining_d = remaining_q - LEN_W'(1);
               if (!lastLane) begin
                  if (idx_q == LAST_IDX) begin
                     permReq_d = 1'b1;
                  end else begin
                     idx_d     = idxNext;
                     outData_d = nextLane;
                  end
               end
            end
         end
         ST_WAIT_PERM: begin
            if (loadFire) begin
               stateReg_d = state_in;
               idx_d      = '0;
               outData_d  = lane(state_in, 0);
            end
         end
         default: ;
      endcase
   end

   // Datapath registers; reset clears everything, abandoning any digest.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateReg_q  <= '0;
         remaining_q <= '0;
         idx_q       <= '0;
         outData_q   <= '0;
         permReq_q   <= 1'b0;
      end else begin
         stateReg_q  <= stateReg_d;
         remaining_q <= remaining_d;
         idx_q       <= idx_d;
         outData_q   <= outData_d;
         permReq_q   <= permReq_d;
      end
   end

endmodule

// File: tb/tb_keccak_squeeze.sv
// ---------------------------------------------------------------------------
// tb_keccak_squeeze
// Two instances (rate 17 and rate 21) share the stimulus signals; sel picks
// which one is driven and observed. Expected lanes come from a queue filled
// with the lanes of each loaded block, in emission order.
// ---------------------------------------------------------------------------
module tb_keccak_squeeze;

   logic          clk;
   logic          rst_n;
   logic          loadValid;
   logic          outReady;
   logic [1599:0] stateIn;
   logic [15:0]   outLanes;
   int            sel;

   logic          loadReadyA, outValidA, outLastA, permReqA, busyA;
   logic [63:0]   outDataA;
   logic          loadReadyB, outValidB, outLastB, permReqB, busyB;
   logic [63:0]   outDataB;

   logic          loadReady, outValid, outLast, permReq, busy;
   logic [63:0]   outData;

   int testsRun;
   int testsFailed;

   typedef struct {
      int sel;
      int nLanes;
      int readyMode;
      int dataMode;
      int expPerms;
   } vec_t;

   vec_t vecs[9];

   keccak_squeeze #(.RATE_LANES(17), .LEN_W(16)) dutA (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (loadValid && (sel == 0)),
      .load_ready (loadReadyA),
      .state_in   (stateIn),
      .out_lanes  (outLanes),
      .out_valid  (outValidA),
      .out_ready  (outReady && (sel == 0)),
      .out_data   (outDataA),
      .out_last   (outLastA),
      .perm_req   (permReqA),
      .busy       (busyA)
   );

   keccak_squeeze #(.RATE_LANES(21), .LEN_W(16)) dutB (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (loadValid && (sel == 1)),
      .load_ready (loadReadyB),
      .state_in   (stateIn),
      .out_lanes  (outLanes),
      .out_valid  (outValidB),
      .out_ready  (outReady && (sel == 1)),
      .out_data   (outDataB),
      .out_last   (outLastB),
      .perm_req   (permReqB),
      .busy       (busyB)
   );

   assign loadReady = (sel == 1) ? loadReadyB : loadReadyA;
   assign outValid  = (sel == 1) ? outValidB  : outValidA;
   assign outLast   = (sel == 1) ? outLastB   : outLastA;
   assign permReq   = (sel == 1) ? permReqB   : permReqA;
   assign busy      = (sel == 1) ? busyB      : busyA;
   assign outData   = (sel == 1) ? outDataB   : outDataA;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Block contents: mode 1 uses the fixed test-plan patterns, mode 0 is random.
   function automatic logic [1599:0] makeBlock(input int mode, input int blk);
      logic [1599:0] s;
      for (int i = 0; i < 25; i++) begin
         if (mode == 1) begin
            if (blk == 0) s[64*i +: 64] = {32'hA5A50000 + 32'(i), 32'h0000_0000 + 32'(i)};
            else          s[64*i +: 64] = 64'hDEAD0000_00000000 + (64'(blk - 1) << 32) + 64'(i);
         end else begin
            s[64*i +: 64] = {$urandom, $urandom};
         end
      end
      return s;
   endfunction

   // Drives one full request on the selected instance and checks every lane
   // against the queue of expected lanes.
   task automatic applyStimulus(input int selIn, input int n, input int readyMode,
                                input int dataMode, output int perms, output int fires);
      logic [63:0] expQ[$];
      bit          pat[7];
      int          rate, owed, blk, take, cyc;
      logic        justLoaded, prevValid, prevFire, fireNow;
      pat        = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      sel        = selIn;
      rate       = (selIn == 1) ? 21 : 17;
      owed       = n;
      blk        = 0;
      perms      = 0;
      fires      = 0;
      cyc        = 0;
      prevValid  = 1'b0;
      prevFire   = 1'b0;
      @(negedge clk);
      stateIn   = makeBlock(dataMode, blk);
      outLanes  = 16'(n);
      loadValid = 1'b1;
      take = (owed < rate) ? owed : rate;
      for (int i = 0; i < take; i++) expQ.push_back(stateIn[64*i +: 64]);
      owed -= take;
      @(negedge clk);
      justLoaded = 1'b1;
      while (fires < n && cyc < 3000) begin
         loadValid = 1'b0;
         case (readyMode)
            0:       outReady = 1'b1;
            1:       outReady = pat[cyc % 7];
            default: outReady = 1'($urandom_range(0, 1));
         endcase
         if (justLoaded) checkOutput("firstLatency", 64'(outValid), 64'd1);
         justLoaded = 1'b0;
         if (prevValid && !prevFire) checkOutput("validHold", 64'(outValid), 64'd1);
         if (permReq) begin
            perms++;
            checkOutput("permTiming", 64'((fires % rate == 0) && (owed > 0)), 64'd1);
            checkOutput("permValidLow", 64'(outValid), 64'd0);
            blk++;
            stateIn   = makeBlock(dataMode, blk);
            loadValid = 1'b1;
            take = (owed < rate) ? owed : rate;
            for (int i = 0; i < take; i++) expQ.push_back(stateIn[64*i +: 64]);
            owed -= take;
            justLoaded = 1'b1;
         end
         fireNow = outValid && outReady;
         if (outValid) begin
            checkOutput("laneData", outData, (expQ.size() > 0) ? expQ[0] : 64'hx);
            checkOutput("laneLast", 64'(outLast), 64'(fires == n - 1));
            checkOutput("loadReadyEmit", 64'(loadReady), 64'd0);
            if (outReady) begin
               if (expQ.size() > 0) void'(expQ.pop_front());
               fires++;
            end
         end
         prevValid = outValid;
         prevFire  = fireNow;
         cyc++;
         @(negedge clk);
      end
      loadValid = 1'b0;
      outReady  = 1'b0;
      if (cyc >= 3000) checkOutput("timeout", 64'(cyc), 64'd0);
      checkOutput("doneValid", 64'(outValid), 64'd0);
      checkOutput("doneBusy", 64'(busy), 64'd0);
      checkOutput("doneLoadReady", 64'(loadReady), 64'd1);
      checkOutput("doneQueue", 64'(expQ.size()), 64'd0);
   endtask

   initial begin
      int perms, fires;
      testsRun    = 0;
      testsFailed = 0;
      sel         = 0;
      loadValid   = 1'b0;
      outReady    = 1'b0;
      stateIn     = '0;
      outLanes    = '0;
      rst_n       = 1'b0;

      //          sel lanes ready data perms
      vecs[0] = '{0,  4,    0,    1,   0};
      vecs[1] = '{0,  4,    1,    1,   0};
      vecs[2] = '{1,  25,   0,    1,   1};
      vecs[3] = '{0,  17,   0,    1,   0};
      vecs[4] = '{0,  18,   2,    0,   1};
      vecs[5] = '{1,  50,   2,    0,   2};
      vecs[6] = '{0,  35,   2,    0,   2};
      vecs[7] = '{1,  1,    0,    0,   0};
      vecs[8] = '{1,  21,   1,    0,   0};

      // Reset values, both instances.
      #2;
      for (int s = 0; s < 2; s++) begin
         sel = s;
         #1;
         checkOutput("rstLoadReady", 64'(loadReady), 64'd1);
         checkOutput("rstValid", 64'(outValid), 64'd0);
         checkOutput("rstLast", 64'(outLast), 64'd0);
         checkOutput("rstData", outData, 64'd0);
         checkOutput("rstPerm", 64'(permReq), 64'd0);
         checkOutput("rstBusy", 64'(busy), 64'd0);
      end
      sel = 0;
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 9; v++) begin
         applyStimulus(vecs[v].sel, vecs[v].nLanes, vecs[v].readyMode,
                       vecs[v].dataMode, perms, fires);
         checkOutput("permCount", 64'(perms), 64'(vecs[v].expPerms));
         checkOutput("laneCount", 64'(fires), 64'(vecs[v].nLanes));
      end

      // Zero-length request is a no-op.
      sel = 0;
      @(negedge clk);
      stateIn   = makeBlock(0, 0);
      outLanes  = 16'd0;
      loadValid = 1'b1;
      @(negedge clk);
      loadValid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         checkOutput("zeroValid", 64'(outValid), 64'd0);
         checkOutput("zeroBusy", 64'(busy), 64'd0);
         checkOutput("zeroLoadReady", 64'(loadReady), 64'd1);
         @(negedge clk);
      end

      // Asynchronous reset after the second lane of a 4-lane request.
      stateIn   = makeBlock(1, 0);
      outLanes  = 16'd4;
      loadValid = 1'b1;
      outReady  = 1'b1;
      @(negedge clk);
      loadValid = 1'b0;
      @(negedge clk);
      checkOutput("preRstData", outData, {32'hA5A50001, 32'h00000001});
      @(negedge clk);
      checkOutput("preRstValid", 64'(outValid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("asyncValid", 64'(outValid), 64'd0);
      checkOutput("asyncData", outData, 64'd0);
      checkOutput("asyncLast", 64'(outLast), 64'd0);
      checkOutput("asyncBusy", 64'(busy), 64'd0);
      checkOutput("asyncLoadReady", 64'(loadReady), 64'd1);
      checkOutput("asyncPerm", 64'(permReq), 64'd0);
      outReady = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, 3, 2, 0, perms, fires);
      checkOutput("postRstPerms", 64'(perms), 64'd0);
      checkOutput("postRstLanes", 64'(fires), 64'd3);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
